uart_tx_multi: RTL and testbench
================================

// Module: uart_tx_multi
// PURPOSE
//  Parametrised UART transmitter: write-side FIFO, runtime-selectable parity and stop bits,
//  and line-break generation. Serialises FIFO bytes onto tx_out, LSB first.
//  Sits in the UART peripheral behind the pipeline LSU MMIO registers; drives the board TX pin.
// PARAMETERS
//  DATA_W     8    payload bits per frame (5..8); fifo_data_in bits above DATA_W-1 are ignored
//  FIFO_DEPTH 16   TX FIFO entries; power of 2, >= 2
//  DIV_W      12   width of baud_divisor
// PORTS
//  clk           in   1            system clock
//  reset         in   1            asynchronous, active-low reset
//  baud_divisor  in   DIV_W        clk cycles per bit; 0 is treated as 1
//  parity_mode   in   2            00 none, 01 even, 10 odd, 11 none
//  two_stop_bits in   1            1 = two stop bits, 0 = one
//  break_req     in   1            hold tx_out low (line break) while high, between frames
//  fifo_wr       in   1            push fifo_data_in this cycle
//  fifo_data_in  in   8            byte to send
//  ovf_clr       in   1            clear the overflow flag
//  tx_out        out  1            serial line; idle high
//  txff / txfe   out  1            FIFO full / FIFO empty
//  fifo_count    out  $clog2(FIFO_DEPTH)+1   current FIFO occupancy
//  tx_busy       out  1            high in any state other than IDLE
//  overflow      out  1            sticky: set when a write is dropped
// BEHAVIOUR
//  Reset: tx_out=1, txfe=1, txff=0, fifo_count=0, tx_busy=0, overflow=0, FSM=IDLE, FIFO cleared.
//  Reset mid-frame aborts the frame at once; the line returns high asynchronously.
//  FIFO write: a push is accepted if !txff, or if txff and a pop occurs in the same cycle.
//   Otherwise the data is dropped and overflow is set. ovf_clr wins over a same-cycle set.
//  Pop: in IDLE with !txfe and !break_req, the FSM pops the head and latches the byte,
//   parity_mode, two_stop_bits and baud_divisor for the whole frame.
//   Config changes mid-frame take effect on the next frame only.
//  Latency: fifo_wr in cycle N into an empty FIFO with FSM IDLE -> txfe=0 in N+1;
//   pop and START in N+1 -> tx_out=0 from N+2.
//  Bit timer: a down-counter reloads to max(div,1)-1; each bit lasts exactly max(div,1) clks.
//  FSM:
//   IDLE -> START (pop) | BREAK (break_req)
//   START -> DATA
//   DATA (DATA_W bits, index 0..DATA_W-1) -> PARITY (mode 01/10) | STOP1
//   PARITY -> STOP1
//   STOP1 -> STOP2 (two_stop) | IDLE
//   STOP2 -> IDLE
//   BREAK -> IDLE when break_req falls; tx_out=0 while in BREAK
//  Parity bit = ^data[DATA_W-1:0] for even; its inverse for odd.
//  Frame length = 1 + DATA_W + (parity?1:0) + (two_stop?2:1) bit periods.
//  break_req asserted mid-frame: the current frame completes, then BREAK is entered.
//   Break has priority over a pending pop.
//  Back-to-back: the next START begins the cycle after STOP ends if !txfe. There is no idle gap.
//  The FIFO pointers wrap modulo FIFO_DEPTH. fifo_count changes by +1/-1/0 on push/pop/both.
// STRUCTURE
//  Package uart_pkg: parity_e enum (PAR_NONE, PAR_EVEN, PAR_ODD), tx_state_e enum,
//   IDLE_LEVEL constant = 1'b1.
//  Sub-module uart_tx_fifo #(W, DEPTH): sync FIFO with count, full, empty and
//   push-when-full-with-pop support.
//  The top holds the FSM, bit timer, bit index counter and shift register.
// TESTING
//  1 div=4, mode=00, 1 stop, write 8'hA5 -> tx_out 0,1,0,1,0,0,1,0,1,1; each bit 4 clks; 40 clks total.
//  2 div=3, mode=01 then 10, byte 8'h07 -> parity bit 1 (even) / 0 (odd); two_stop=1 gives 2 stop periods.
//  3 FIFO_DEPTH=4, 6 writes with no pop gap -> first byte popped; txff asserted;
//    6th write dropped; overflow=1 until ovf_clr; 5 frames sent back to back.
//  4 break_req raised during DATA bit 3 -> frame finishes; tx_out low until break_req
//    falls; queued byte then sent.
//  5 reset low during the PARITY bit -> tx_out=1, txfe=1, fifo_count=0 immediately; no stale bits after release.
//  6 DATA_W=5, div=0 -> byte 8'hFF sent as 5 data bits with 1-clk bit period; frame = 7 clks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
package uart_pkg;

   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10
   } parity_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2,
      S_BREAK
   } tx_state_e;

   // Mode 2'b11 is reserved and behaves as no parity.
   function automatic parity_e decode_parity(input logic [1:0] mode);
      case (mode)
         2'b01:   return PAR_EVEN;
         2'b10:   return PAR_ODD;
         default: return PAR_NONE;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX FIFO with occupancy count; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module uart_tx_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     push_ok
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_pop;

   assign do_pop  = pop && !empty;
   assign push_ok = push && (!full || do_pop);
   assign full    = (count == DEPTH_CNT);
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_tx_multi.sv
// UART transmitter: FIFO-fed serialiser with per-frame parity/stop configuration
// and line-break generation. tx_out is registered so the pin never glitches.
module uart_tx_multi
   import uart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 12
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DIV_W-1:0]              baud_divisor,
   input  logic [1:0]                    parity_mode,
   input  logic                          two_stop_bits,
   input  logic                          break_req,
   input  logic                          fifo_wr,
   input  logic [7:0]                    fifo_data_in,
   input  logic                          ovf_clr,
   output logic                          tx_out,
   output logic                          txff,
   output logic                          txfe,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          tx_busy,
   output logic                          overflow
);

   localparam int IDXW = $clog2(DATA_W);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DATA_W - 1);

   function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
      return (d == '0) ? DIV_W'(1) : d;
   endfunction

   function automatic logic parity_bit(input logic [DATA_W-1:0] d, input parity_e p);
      return (^d) ^ (p == PAR_ODD);
   endfunction

   tx_state_e         state_q, state_d;
   logic              line_q, line_d;
   logic [DIV_W-1:0]  tmr_q, tmr_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic              par_en_q, par_en_d;
   logic              par_q, par_d;
   logic              two_q, two_d;
   logic              pop, push_ok, bit_end, frame_done;
   logic [DATA_W-1:0] head;
   parity_e           par_sel;

   uart_tx_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_wr),
      .push_data (fifo_data_in[DATA_W-1:0]),
      .pop       (pop),
      .head      (head),
      .full      (txff),
      .empty     (txfe),
      .count     (fifo_count),
      .push_ok   (push_ok)
   );

   assign par_sel = decode_parity(parity_mode);

   always_comb begin
      state_d    = state_q;
      line_d     = line_q;
      idx_d      = idx_q;
      sh_d       = sh_q;
      div_d      = div_q;
      par_en_d   = par_en_q;
      par_d      = par_q;
      two_d      = two_q;
      pop        = 1'b0;
      frame_done = 1'b0;
      bit_end    = (tmr_q == '0);
      tmr_d      = bit_end ? (div_q - 1'b1) : (tmr_q - 1'b1);

      case (state_q)
         S_IDLE:   frame_done = 1'b1;
         S_START:  if (bit_end) begin
                      state_d = S_DATA;
                      idx_d   = '0;
                      line_d  = sh_q[0];
                   end
         S_DATA:   if (bit_end) begin
                      if (idx_q == IDX_LAST) begin
                         state_d = par_en_q ? S_PARITY : S_STOP1;
                         line_d  = par_en_q ? par_q : IDLE_LEVEL;
                      end else begin
                         idx_d  = idx_q + 1'b1;
                         sh_d   = sh_q >> 1;
                         line_d = sh_q[1];
                      end
                   end
         S_PARITY: if (bit_end) begin
                      state_d = S_STOP1;
                      line_d  = IDLE_LEVEL;
                   end
         S_STOP1:  if (bit_end) begin
                      if (two_q) state_d = S_STOP2;
                      else       frame_done = 1'b1;
                   end
         S_STOP2:  if (bit_end) frame_done = 1'b1;
         S_BREAK:  if (!break_req) begin
                      state_d = S_IDLE;
                      line_d  = IDLE_LEVEL;
                   end
         default:  state_d = S_IDLE;
      endcase

      // End of a frame behaves like IDLE so back-to-back frames have no gap.
      if (frame_done) begin
         state_d = S_IDLE;
         line_d  = IDLE_LEVEL;
         if (break_req) begin
            state_d = S_BREAK;
            line_d  = 1'b0;
         end else if (!txfe) begin
            pop      = 1'b1;
            state_d  = S_START;
            line_d   = 1'b0;
            sh_d     = head;
            div_d    = eff_div(baud_divisor);
            tmr_d    = eff_div(baud_divisor) - 1'b1;
            par_en_d = (par_sel != PAR_NONE);
            par_d    = parity_bit(head, par_sel);
            two_d    = two_stop_bits;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         line_q   <= IDLE_LEVEL;
         overflow <= 1'b0;
      end else begin
         state_q <= state_d;
         line_q  <= line_d;
         if (ovf_clr)                 overflow <= 1'b0;
         else if (fifo_wr && !push_ok) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      tmr_q    <= tmr_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      sh_q     <= sh_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
      two_q    <= two_d;
   end

   assign tx_out  = line_q;
   assign tx_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_multi.sv
// Directed bench for uart_tx_multi: 8-bit/depth-4 instance plus a 5-bit instance.
module tb_uart_tx_multi;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] baud_divisor;
   logic [1:0]  parity_mode;
   logic        two_stop_bits;
   logic        break_req;
   logic        fifo_wr;
   logic [7:0]  fifo_data_in;
   logic        ovf_clr;
   logic        tx_out, txff, txfe, tx_busy, overflow;
   logic [2:0]  fifo_count;

   logic        fifo_wr5;
   logic [7:0]  fifo_data5;
   logic        break5;
   logic        ovf_clr5;
   logic        tx_out5, txff5, txfe5, tx_busy5, overflow5;
   logic [4:0]  fifo_count5;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_multi #(.DATA_W(8), .FIFO_DEPTH(4), .DIV_W(12)) dut (
      .clk           (clk),
      .reset         (reset),
      .baud_divisor  (baud_divisor),
      .parity_mode   (parity_mode),
      .two_stop_bits (two_stop_bits),
      .break_req     (break_req),
      .fifo_wr       (fifo_wr),
      .fifo_data_in  (fifo_data_in),
      .ovf_clr       (ovf_clr),
      .tx_out        (tx_out),
      .txff          (txff),
      .txfe          (txfe),
      .fifo_count    (fifo_count),
      .tx_busy       (tx_busy),
      .overflow      (overflow)
   );

   uart_tx_multi #(.DATA_W(5), .FIFO_DEPTH(16), .DIV_W(12)) dut5 (
      .clk           (clk),
      .reset         (reset),
      .baud_divisor  (baud_divisor),
      .parity_mode   (parity_mode),
      .two_stop_bits (two_stop_bits),
      .break_req     (break5),
      .fifo_wr       (fifo_wr5),
      .fifo_data_in  (fifo_data5),
      .ovf_clr       (ovf_clr5),
      .tx_out        (tx_out5),
      .txff          (txff5),
      .txfe          (txfe5),
      .fifo_count    (fifo_count5),
      .tx_busy       (tx_busy5),
      .overflow      (overflow5)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic line(input int sel);
      return (sel != 0) ? tx_out5 : tx_out;
   endfunction

   task automatic push(input int sel, input logic [7:0] b);
      if (sel == 0) begin
         fifo_wr      = 1'b1;
         fifo_data_in = b;
      end else begin
         fifo_wr5   = 1'b1;
         fifo_data5 = b;
      end
      @(negedge clk);
      fifo_wr  = 1'b0;
      fifo_wr5 = 1'b0;
   endtask

   // Waits for the start bit, then checks every clock of the frame against a
   // hand-built bit list. Returns the number of cycles spent waiting.
   task automatic check_frame(input int sel, input logic [7:0] data, input int nb,
                              input logic [1:0] mode, input logic two, input int div,
                              output int waits);
      logic [15:0] fr;
      logic [7:0]  m;
      logic        p;
      int          len;
      int          dv;
      int          found;
      dv    = (div == 0) ? 1 : div;
      m     = data & 8'((1 << nb) - 1);
      p     = ^m;
      fr    = '0;
      fr[0] = 1'b0;
      for (int i = 0; i < nb; i++) fr[1+i] = m[i];
      len = 1 + nb;
      if (mode == 2'b01) begin fr[len] = p;  len++; end
      if (mode == 2'b10) begin fr[len] = ~p; len++; end
      fr[len] = 1'b1; len++;
      if (two) begin fr[len] = 1'b1; len++; end
      waits = 0;
      found = 0;
      for (int w = 0; w < 200; w++) begin
         if (line(sel) == 1'b0) begin
            found = 1;
            break;
         end
         waits++;
         @(negedge clk);
      end
      check($sformatf("start_seen_%0h", data), found, 1);
      if (found != 0) begin
         for (int i = 0; i < len * dv; i++) begin
            check($sformatf("frame_%0h_clk%0d", data, i), line(sel), fr[i/dv]);
            @(negedge clk);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      logic [7:0] t3 [5];
      t3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      baud_divisor = 12'd4; parity_mode = 2'b00; two_stop_bits = 1'b0;
      break_req = 1'b0; fifo_wr = 1'b0; fifo_data_in = 8'h00; ovf_clr = 1'b0;
      fifo_wr5 = 1'b0; fifo_data5 = 8'h00; break5 = 1'b0; ovf_clr5 = 1'b0;
      reset = 1'b1;
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx_out", tx_out, 1);
      check("rst_txfe", txfe, 1);
      check("rst_txff", txff, 0);
      check("rst_count", fifo_count, 0);
      check("rst_busy", tx_busy, 0);
      check("rst_ovf", overflow, 0);
      check("rst5_tx_out", tx_out5, 1);
      check("rst5_flags", {txff5, overflow5, txfe5}, 3'b001);
      reset = 1'b1;
      @(negedge clk);

      // 8'hA5, div 4, no parity, one stop
      push(0, 8'hA5);
      check("t1_txfe_after_wr", txfe, 0);
      check_frame(0, 8'hA5, 8, 2'b00, 1'b0, 4, w);
      check("t1_latency", w, 1);
      check("t1_idle_line", tx_out, 1);
      check("t1_idle_busy", tx_busy, 0);
      check("t1_empty", txfe, 1);

      // even parity, then odd parity + two stops with config changed mid-frame
      baud_divisor = 12'd3; parity_mode = 2'b01; two_stop_bits = 1'b0;
      push(0, 8'h07);
      check_frame(0, 8'h07, 8, 2'b01, 1'b0, 3, w);
      parity_mode = 2'b10; two_stop_bits = 1'b1;
      push(0, 8'h07);
      fork
         check_frame(0, 8'h07, 8, 2'b10, 1'b1, 3, w);
         begin
            repeat (5) @(negedge clk);
            parity_mode = 2'b01; two_stop_bits = 1'b0; baud_divisor = 12'd5;
         end
      join
      check("t2_idle_line", tx_out, 1);

      // FIFO fill, overflow and back-to-back frames
      baud_divisor = 12'd2; parity_mode = 2'b00; two_stop_bits = 1'b0;
      fork
         begin
            for (int k = 0; k < 5; k++) begin
               check_frame(0, t3[k], 8, 2'b00, 1'b0, 2, w);
               if (k > 0) check($sformatf("t3_b2b_%0d", k), w, 0);
            end
         end
         begin
            fifo_wr = 1'b1;
            fifo_data_in = 8'h11; @(negedge clk);
            fifo_data_in = 8'h22; @(negedge clk);
            fifo_data_in = 8'h33; @(negedge clk);
            fifo_data_in = 8'h44; @(negedge clk);
            fifo_data_in = 8'h55; @(negedge clk);
            check("t3_txff", txff, 1);
            check("t3_count_full", fifo_count, 4);
            check("t3_no_ovf_yet", overflow, 0);
            fifo_data_in = 8'h66; @(negedge clk);
            fifo_wr = 1'b0;
            check("t3_ovf_set", overflow, 1);
            check("t3_count_kept", fifo_count, 4);
            repeat (5) @(negedge clk);
            check("t3_ovf_sticky", overflow, 1);
            ovf_clr = 1'b1; @(negedge clk);
            ovf_clr = 1'b0;
            check("t3_ovf_clr", overflow, 0);
         end
      join
      check("t3_empty", txfe, 1);
      check("t3_busy", tx_busy, 0);
      for (int i = 0; i < 6; i++) begin
         check("t3_no_sixth", tx_out, 1);
         @(negedge clk);
      end

      // break raised during data bit 3 with a byte queued
      baud_divisor = 12'd4;
      push(0, 8'h3C);
      push(0, 8'h81);
      fork
         begin
            check_frame(0, 8'h3C, 8, 2'b00, 1'b0, 4, w);
            check("t4_start", w, 0);
            for (int i = 0; i < 10; i++) begin
               check("t4_break_line", tx_out, 0);
               check("t4_queued", txfe, 0);
               @(negedge clk);
            end
         end
         begin
            repeat (17) @(negedge clk);
            break_req = 1'b1;
            repeat (40) @(negedge clk);
            break_req = 1'b0;
         end
      join
      check("t4_break_busy", tx_busy, 1);
      check("t4_break_tail", tx_out, 0);
      @(negedge clk);
      check("t4_break_exit", tx_out, 1);
      check_frame(0, 8'h81, 8, 2'b00, 1'b0, 4, w);
      check("t4_resume_latency", w, 1);

      // asynchronous reset during the parity bit
      baud_divisor = 12'd3; parity_mode = 2'b10; two_stop_bits = 1'b0;
      push(0, 8'h07);
      push(0, 8'h55);
      repeat (28) @(negedge clk);
      check("t5_in_parity", tx_out, 0);
      check("t5_queued", fifo_count, 1);
      reset = 1'b0;
      #1;
      check("t5_rst_line", tx_out, 1);
      check("t5_rst_txfe", txfe, 1);
      check("t5_rst_count", fifo_count, 0);
      check("t5_rst_busy", tx_busy, 0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("t5_quiet", tx_out, 1);
      end
      check("t5_quiet_busy", tx_busy, 0);

      // 5-bit instance, divisor 0
      baud_divisor = 12'd0; parity_mode = 2'b00; two_stop_bits = 1'b0;
      push(1, 8'hFF);
      check_frame(1, 8'hFF, 5, 2'b00, 1'b0, 0, w);
      check("t6_latency", w, 1);
      push(1, 8'hE2);
      check_frame(1, 8'hE2, 5, 2'b00, 1'b0, 0, w);
      check("t6_idle_line", tx_out5, 1);
      check("t6_empty", txfe5, 1);
      check("t6_busy", tx_busy5, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
